aes_key_schedule_seq: RTL and testbench

Sequential AES key-expansion engine that sits directly upstream of the `Cipher` round datapath. It accepts a 128/192/256-bit cipher key and produces the full packed round-key schedule that `Cipher` consumes. It generates one 32-bit schedule word per clock instead of unrolling all words combinationally, which trades latency for area. The output format is bit-identical to the combinational `KeyExpansion` output, so `Cipher` connects without change.

---
 rtl/aes_key_schedule_seq_pkg.sv | 40 ++++
 rtl/aes_key_schedule_seq_if.sv | 21 ++
 rtl/aes_key_schedule_seq_sbox.sv | 9 +
 rtl/aes_key_schedule_seq.sv | 119 +++++++++++
 tb/tb_aes_key_schedule_seq.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_schedule_seq_pkg.sv
// Shared AES constants (block width, S-box, round constants) and the key-schedule FSM states.
package aes_key_schedule_seq_pkg;

    localparam int NB = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Ten entries cover AES-128, the longest consumer of round constants.
    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// Key-schedule request/result bundle: start + key towards the engine, status + packed schedule back.
interface aes_key_schedule_seq_if #(
    parameter int Nk = 4,
    parameter int Nr = 10
);
    logic                       start;
    logic [0:32*Nk-1]           key_in;
    logic                       busy;
    logic                       done;
    logic [0:128*(Nr+1)-1]      key_schedule;

    modport master (
        output start, key_in,
        input  busy, done, key_schedule
    );

    modport slave (
        input  start, key_in,
        output busy, done, key_schedule
    );
endinterface

// File: rtl/aes_key_schedule_seq_sbox.sv
// Combinational AES S-box byte lookup; shared with the cipher SubBytes path.
module aes_key_schedule_seq_sbox (
    input  logic [7:0] plain,
    output logic [7:0] subst
);
    import aes_key_schedule_seq_pkg::*;

    assign subst = SBOX[plain];
endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES key expansion: one 32-bit schedule word per clock, done pulses N edges after start.
// No backpressure; start is taken in IDLE and on the edge leaving DONE, ignored during RUN.
module aes_key_schedule_seq #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    aes_key_schedule_seq_if.slave bus
);
    import aes_key_schedule_seq_pkg::*;

    localparam int WORDS = NB * (Nr + 1);
    localparam int SBITS = 32 * WORDS;
    localparam int AW    = $clog2(SBITS);

    state_t           state;
    state_t           next_state;
    logic [5:0]       idx;
    logic [5:0]       rd_idx;
    logic [2:0]       wrap;
    logic [3:0]       rcon_idx;
    logic [3:0]       rcon_sel;
    logic [0:SBITS-1] sched;
    logic [AW-1:0]    wr_pos;
    logic [AW-1:0]    prev_pos;
    logic [AW-1:0]    back_pos;
    logic [31:0]      prev_word;
    logic [31:0]      back_word;
    logic [31:0]      sub_in;
    logic [31:0]      sub_out;
    logic [31:0]      temp;
    logic [31:0]      new_word;
    logic             accept;
    logic             last_word;

    // The edge leaving DONE also samples start so back-to-back keys run every N+1 cycles.
    assign accept    = ((state == IDLE) || (state == DONE)) && bus.start;
    assign last_word = (int'(idx) == WORDS - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) next_state = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_word) next_state = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                next_state = bus.start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outside RUN idx may sit below Nk; clamp so the read selects stay in range.
    assign rd_idx    = (int'(idx) >= Nk) ? idx : 6'(Nk);
    assign wr_pos    = AW'(32 * int'(idx));
    assign prev_pos  = AW'(32 * (int'(rd_idx) - 1));
    assign back_pos  = AW'(32 * (int'(rd_idx) - Nk));
    assign prev_word = sched[prev_pos +: 32];
    assign back_word = sched[back_pos +: 32];

    assign sub_in   = (wrap == 3'd0) ? rot_word(prev_word) : prev_word;
    assign rcon_sel = (rcon_idx > 4'd9) ? 4'd9 : rcon_idx;

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_key_schedule_seq_sbox u_sbox (
            .plain (sub_in[8*b +: 8]),
            .subst (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        temp = prev_word;
        if (wrap == 3'd0) begin
            temp = sub_out ^ {RCON[rcon_sel], 24'h0};
        end else if ((Nk == 8) && (wrap == 3'd4)) begin
            temp = sub_out;
        end
    end

    assign new_word = back_word ^ temp;

    always_ff @(posedge clk) begin
        if (reset) begin
            sched    <= '0;
            idx      <= '0;
            wrap     <= '0;
            rcon_idx <= '0;
        end else if (accept) begin
            sched[0:32*Nk-1] <= bus.key_in;
            idx              <= 6'(Nk);
            wrap             <= '0;
            rcon_idx         <= '0;
        end else if (state == RUN) begin
            sched[wr_pos +: 32] <= new_word;
            idx                 <= idx + 6'd1;
            wrap                <= (int'(wrap) == Nk - 1) ? 3'd0 : wrap + 3'd1;
            if (wrap == 3'd0) rcon_idx <= rcon_idx + 4'd1;
        end
    end

    assign bus.key_schedule = sched;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Bench for the sequential key schedule: known-answer table, random keys against a GF(2^8) reference, corner sequences.
module tb_aes_key_schedule_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aes_key_schedule_seq_if #(.Nk(4), .Nr(10)) if4 ();
    aes_key_schedule_seq_if #(.Nk(6), .Nr(12)) if6 ();
    aes_key_schedule_seq_if #(.Nk(8), .Nr(14)) if8 ();

    aes_key_schedule_seq #(.Nk(4), .Nr(10)) dut4 (.clk(clk), .reset(reset), .bus(if4));
    aes_key_schedule_seq #(.Nk(6), .Nr(12)) dut6 (.clk(clk), .reset(reset), .bus(if6));
    aes_key_schedule_seq #(.Nk(8), .Nr(14)) dut8 (.clk(clk), .reset(reset), .bus(if8));

    int total = 0;
    int bad   = 0;

    logic [7:0]  sbox_m [256];
    logic [31:0] exp_w  [60];

    typedef struct {
        int           nk;
        logic [255:0] key;
        int           idx;
        logic [31:0]  word;
        logic [127:0] last;
    } vec_t;
    vec_t vecs [4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse in GF(2^8), then the affine map.
    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
            end
            sbox_m[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic model_expand(input int nk, input logic [255:0] key);
        int          nw;
        logic [7:0]  rc;
        logic [31:0] t;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        for (int j = 0; j < nk; j++) exp_w[j] = key[255 - 32*j -: 32];
        for (int j = nk; j < nw; j++) begin
            t = exp_w[j-1];
            if (j % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk > 6 && j % nk == 4) begin
                t = subw(t);
            end
            exp_w[j] = exp_w[j-nk] ^ t;
        end
    endtask

    task automatic set_start(input int nk, input logic s, input logic [255:0] key);
        case (nk)
            4:       begin if4.start = s; if4.key_in = key[255 -: 128]; end
            6:       begin if6.start = s; if6.key_in = key[255 -: 192]; end
            default: begin if8.start = s; if8.key_in = key; end
        endcase
    endtask

    function automatic logic get_done(input int nk);
        case (nk)
            4:       return if4.done;
            6:       return if6.done;
            default: return if8.done;
        endcase
    endfunction

    function automatic logic get_busy(input int nk);
        case (nk)
            4:       return if4.busy;
            6:       return if6.busy;
            default: return if8.busy;
        endcase
    endfunction

    function automatic logic [31:0] dut_word(input int nk, input int j);
        case (nk)
            4:       return if4.key_schedule[32*j +: 32];
            6:       return if6.key_schedule[32*j +: 32];
            default: return if8.key_schedule[32*j +: 32];
        endcase
    endfunction

    function automatic logic [127:0] dut_last(input int nk);
        int nw;
        nw = 4 * (nk + 7);
        return {dut_word(nk, nw-4), dut_word(nk, nw-3), dut_word(nk, nw-2), dut_word(nk, nw-1)};
    endfunction

    task automatic cmp_sched(input int nk, input string name);
        int nw;
        int diff;
        int first;
        nw    = 4 * (nk + 7);
        diff  = 0;
        first = 0;
        for (int j = nw - 1; j >= 0; j--) begin
            if (dut_word(nk, j) !== exp_w[j]) begin
                diff++;
                first = j;
            end
        end
        total++;
        if (diff != 0) begin
            bad++;
            $display("FAIL %s: %0d words differ, w[%0d] got %h want %h",
                     name, diff, first, dut_word(nk, first), exp_w[first]);
        end
    endtask

    // Present key for one edge, then count edges until done (lat) and cycles with busy high.
    task automatic run_key(input int nk, input logic [255:0] key, output int lat, output int bcnt);
        set_start(nk, 1'b1, key);
        @(posedge clk);
        #1;
        set_start(nk, 1'b0, key);
        lat  = 0;
        bcnt = 0;
        while (!get_done(nk) && lat < 200) begin
            if (get_busy(nk)) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           lat;
        int           bcnt;
        int           nk;
        int           ndone;
        int           prev_t;
        logic [255:0] key;
        logic [255:0] key_b;

        vecs[0] = '{nk: 4, key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    idx: 4, word: 32'ha0fafe17, last: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{nk: 4, key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    idx: 4, word: 32'hd6aa74fd, last: 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[2] = '{nk: 6, key: {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    idx: 6, word: 32'h5846f2f9, last: 128'ha4970a331a78dc09c418c271e3a41d5d};
        vecs[3] = '{nk: 8, key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    idx: 8, word: 32'ha573c29f, last: 128'h24fc79ccbf0979e9371ac23c6d68de36};

        reset = 1'b1;
        set_start(4, 1'b0, 256'h0);
        set_start(6, 1'b0, 256'h0);
        set_start(8, 1'b0, 256'h0);
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 128'(if4.busy), 128'h0);
        check("reset_done", 128'(if4.done), 128'h0);
        check("reset_sched4", 128'(|if4.key_schedule), 128'h0);
        check("reset_sched8", 128'(|if8.key_schedule), 128'h0);
        reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            nk = vecs[v].nk;
            run_key(nk, vecs[v].key, lat, bcnt);
            check($sformatf("vec%0d_latency", v), 128'(lat), 128'(3*nk + 28));
            check($sformatf("vec%0d_busy_cycles", v), 128'(bcnt), 128'(3*nk + 28));
            check($sformatf("vec%0d_word", v), 128'(dut_word(nk, vecs[v].idx)), 128'(vecs[v].word));
            check($sformatf("vec%0d_last_round_key", v), dut_last(nk), vecs[v].last);
            model_expand(nk, vecs[v].key);
            cmp_sched(nk, $sformatf("vec%0d_model", v));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_one_cycle", v), 128'(get_done(nk)), 128'h0);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("vec%0d_stable", v), dut_last(nk), vecs[v].last);
        end

        for (int r = 0; r < 9; r++) begin
            nk = 4 + 2 * (r % 3);
            for (int k = 0; k < 8; k++) key[255 - 32*k -: 32] = $urandom;
            model_expand(nk, key);
            run_key(nk, key, lat, bcnt);
            check($sformatf("rand%0d_latency", r), 128'(lat), 128'(3*nk + 28));
            cmp_sched(nk, $sformatf("rand%0d_model", r));
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end

        // A second start with another key arrives at cycle 10 of a run.
        for (int k = 0; k < 8; k++) key[255 - 32*k -: 32] = $urandom;
        key_b = ~key;
        model_expand(4, key);
        set_start(4, 1'b1, key);
        @(posedge clk);
        #1;
        set_start(4, 1'b0, key);
        ndone = 0;
        for (int c = 1; c <= 50; c++) begin
            if (c == 10) set_start(4, 1'b1, key_b);
            if (c == 11) set_start(4, 1'b0, key_b);
            @(posedge clk);
            #1;
            if (get_done(4)) ndone++;
        end
        check("busy_start_done_count", 128'(ndone), 128'd1);
        cmp_sched(4, "busy_start_schedule");

        // start held high: consecutive done pulses are N+1 cycles apart.
        for (int k = 0; k < 8; k++) key[255 - 32*k -: 32] = $urandom;
        model_expand(4, key);
        set_start(4, 1'b1, key);
        ndone  = 0;
        prev_t = 0;
        for (int t = 1; t <= 200 && ndone < 3; t++) begin
            @(posedge clk);
            #1;
            if (get_done(4)) begin
                if (ndone > 0) check("b2b_period", 128'(t - prev_t), 128'd41);
                prev_t = t;
                ndone++;
            end
        end
        set_start(4, 1'b0, key);
        check("b2b_runs", 128'(ndone), 128'd3);
        cmp_sched(4, "b2b_schedule");
        @(posedge clk);
        #1;
        check("b2b_idle_busy", 128'(if4.busy), 128'h0);

        // Reset lands on edge 20 of a run.
        for (int k = 0; k < 8; k++) key[255 - 32*k -: 32] = $urandom;
        set_start(4, 1'b1, key);
        @(posedge clk);
        #1;
        set_start(4, 1'b0, key);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_busy", 128'(if4.busy), 128'h0);
        check("midrst_done", 128'(if4.done), 128'h0);
        check("midrst_sched_zero", 128'(|if4.key_schedule), 128'h0);
        ndone = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (if4.done) ndone++;
        end
        check("midrst_no_done", 128'(ndone), 128'h0);
        model_expand(4, key);
        run_key(4, key, lat, bcnt);
        check("midrst_restart_latency", 128'(lat), 128'd40);
        cmp_sched(4, "midrst_restart_schedule");

        // Reset and start on the same edge: reset wins, nothing is captured.
        @(posedge clk);
        #1;
        reset = 1'b1;
        set_start(4, 1'b1, key);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_start(4, 1'b0, key);
        check("rst_start_busy", 128'(if4.busy), 128'h0);
        check("rst_start_sched_zero", 128'(|if4.key_schedule), 128'h0);
        @(posedge clk);
        #1;
        check("rst_start_still_idle", 128'(if4.busy), 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
